// File: rtl/sevenseg_capture.sv
// Seven-segment bus receiver: settles, decodes and rebuilds an 8-digit frame.
// Optional error counter output enabled by SEVENSEG_CAPTURE_ERRCNT_EN.
module sevenseg_capture #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] an,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] dig4,
    output logic [3:0] dig5,
    output logic [3:0] dig6,
    output logic [3:0] dig7,
    output logic       frame_valid,
    output logic       an_err,
    output logic       seg_err
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    logic [14:0] sync_q [SYNC_STAGES];
    logic [14:0] s;
    logic [14:0] p_q;
    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_nxt;
    logic [3:0]  stage_q [8];
    logic [3:0]  dig_q [8];
    logic [7:0]  seen_q;
    logic [7:0]  seen_d;
    logic        fv_q;
    logic        an_err_q;
    logic        seg_err_q;

    logic        changed;
    logic        cap;
    logic [7:0]  an_s;
    logic [6:0]  lit;
    logic        blank;
    logic        one_low;
    logic [2:0]  idx;
    logic        dec_ok;
    logic [3:0]  dec_val;
    logic        wr;
    logic        done;
    logic        an_err_d;
    logic        seg_err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= {an, a, b, c, d, e, f, g};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign an_s    = s[14:7];
    assign lit     = ~s[6:0];
    assign changed = (s != p_q);
    assign cnt_nxt = cnt_q + 8'd1;
    assign cap     = (state_q == SETTLE) && !changed && (cnt_nxt >= SETTLE_N);
    assign blank   = &an_s;
    assign one_low = $onehot(~an_s);
    assign done    = (seen_q == 8'hFF);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an_s[i]) idx = 3'(i);
        end
    end

    // lit bit order is {a,b,c,d,e,f,g}
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        case (lit)
            7'h7E: dec_val = 4'h0;
            7'h30: dec_val = 4'h1;
            7'h6D: dec_val = 4'h2;
            7'h79: dec_val = 4'h3;
            7'h33: dec_val = 4'h4;
            7'h5B: dec_val = 4'h5;
            7'h5F: dec_val = 4'h6;
            7'h70: dec_val = 4'h7;
            7'h7F: dec_val = 4'h8;
            7'h7B: dec_val = 4'h9;
            7'h77: dec_val = 4'hA;
            7'h1F: dec_val = 4'hB;
            7'h4E: dec_val = 4'hC;
            7'h3D: dec_val = 4'hD;
            7'h4F: dec_val = 4'hE;
            7'h47: dec_val = 4'hF;
            default: dec_ok = 1'b0;
        endcase
    end

    assign wr        = cap && one_low && dec_ok;
    assign an_err_d  = cap && !blank && !one_low;
    assign seg_err_d = cap && one_low && !dec_ok;

    always_comb begin
        seen_d = done ? 8'h00 : seen_q;
        if (wr) seen_d[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            p_q     <= '1;
        end else begin
            p_q <= s;
            case (state_q)
                IDLE: begin
                    if (changed) begin
                        state_q <= SETTLE;
                        cnt_q   <= 8'd1;
                    end
                end
                SETTLE: begin
                    if (changed) begin
                        cnt_q <= 8'd1;
                    end else begin
                        cnt_q <= cnt_nxt;
                        if (cap) state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (changed) begin
                        state_q <= SETTLE;
                        cnt_q   <= 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                stage_q[i] <= 4'h0;
                dig_q[i]   <= 4'h0;
            end
            seen_q    <= 8'h00;
            fv_q      <= 1'b0;
            an_err_q  <= 1'b0;
            seg_err_q <= 1'b0;
        end else begin
            seen_q    <= seen_d;
            fv_q      <= done;
            an_err_q  <= an_err_d;
            seg_err_q <= seg_err_d;
            if (done) begin
                for (int i = 0; i < 8; i++) dig_q[i] <= stage_q[i];
            end
            if (wr) stage_q[idx] <= dec_val;
        end
    end

`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_cnt_q;
    logic       frame_err_q;

    // Errors and frame completion come from captures at least two cycles apart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q   <= 8'd0;
            frame_err_q <= 1'b0;
        end else if (an_err_d || seg_err_d) begin
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            frame_err_q <= 1'b1;
        end else if (done) begin
            if (!frame_err_q) err_cnt_q <= 8'd0;
            frame_err_q <= 1'b0;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign dig0        = dig_q[0];
    assign dig1        = dig_q[1];
    assign dig2        = dig_q[2];
    assign dig3        = dig_q[3];
    assign dig4        = dig_q[4];
    assign dig5        = dig_q[5];
    assign dig6        = dig_q[6];
    assign dig7        = dig_q[7];
    assign frame_valid = fv_q;
    assign an_err      = an_err_q;
    assign seg_err     = seg_err_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed-vector bench for sevenseg_capture: frames, latency, glitch,
// decode errors and reset behaviour.
module tb_sevenseg_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] an = 8'hFF;
    logic       a = 1'b1, b = 1'b1, c = 1'b1, d = 1'b1;
    logic       e = 1'b1, f = 1'b1, g = 1'b1;
    logic [3:0] dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7;
    logic       frame_valid, an_err, seg_err;
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
    logic [7:0] err_count;
`endif

    sevenseg_capture #(.SYNC_STAGES(2), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .an(an),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .dig4(dig4), .dig5(dig5), .dig6(dig6), .dig7(dig7),
        .frame_valid(frame_valid), .an_err(an_err), .seg_err(seg_err)
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int fv_n = 0, ae_n = 0, se_n = 0;

    typedef struct {
        logic [7:0] an;
        logic [6:0] lit;
        int         ae;
        int         se;
        int         fv;
    } row_t;

    row_t rows[$];

    always @(posedge clk) begin
        #1;
        if (frame_valid) fv_n++;
        if (an_err) ae_n++;
        if (seg_err) se_n++;
    end

    // Lit segments {a,b,c,d,e,f,g} for each hex value.
    function automatic logic [6:0] hexlit(int v);
        case (v)
            0: return 7'h7E;   1: return 7'h30;   2: return 7'h6D;   3: return 7'h79;
            4: return 7'h33;   5: return 7'h5B;   6: return 7'h5F;   7: return 7'h70;
            8: return 7'h7F;   9: return 7'h7B;  10: return 7'h77;  11: return 7'h1F;
            12: return 7'h4E; 13: return 7'h3D;  14: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    function automatic logic [31:0] digs();
        return {dig7, dig6, dig5, dig4, dig3, dig2, dig1, dig0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] av, input logic [6:0] lv);
        an = av;
        {a, b, c, d, e, f, g} = ~lv;
    endtask

    task automatic add(input logic [7:0] av, input logic [6:0] lv,
                       input int ae, input int se, input int fv);
        row_t r;
        r.an = av; r.lit = lv; r.ae = ae; r.se = se; r.fv = fv;
        rows.push_back(r);
    endtask

    task automatic run_rows(input string tag);
        int ae0, se0, fv0;
        foreach (rows[i]) begin
            ae0 = ae_n; se0 = se_n; fv0 = fv_n;
            drive(rows[i].an, rows[i].lit);
            repeat (16) @(negedge clk);
            check($sformatf("%s[%0d].an_err", tag, i), ae_n - ae0, rows[i].ae);
            check($sformatf("%s[%0d].seg_err", tag, i), se_n - se0, rows[i].se);
            check($sformatf("%s[%0d].frame_valid", tag, i), fv_n - fv0, rows[i].fv);
        end
        rows.delete();
    endtask

    task automatic add_frame(input int base, input int step);
        for (int k = 0; k < 8; k++) begin
            add(~(8'h01 << k), hexlit(base + step * k), 0, 0, (k == 7) ? 1 : 0);
        end
    endtask

    initial begin
        int lat;
        int fv0, se0;

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.digits", digs(), 32'h0);
        check("reset.frame_valid", frame_valid, 0);
        check("reset.an_err", an_err, 0);
        check("reset.seg_err", seg_err, 0);
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
        check("reset.err_count", err_count, 0);
`endif
        rst = 1'b1;

        add_frame(0, 1);
        run_rows("frame01234567");
        check("frame01234567.digits", digs(), 32'h76543210);

        add_frame(8, 1);
        run_rows("frame89ABCDEF");
        check("frame89ABCDEF.digits", digs(), 32'hFEDCBA98);

        for (int k = 1; k < 8; k++) add(~(8'h01 << k), hexlit(7 + k), 0, 0, 0);
        add(8'hFF, 7'h00, 0, 0, 0);
        run_rows("latency.pre");
        drive(8'hFE, hexlit(1));
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (frame_valid) begin
                lat = i;
                break;
            end
        end
        check("latency.cycles", lat, 7);
        check("latency.digits", digs(), 32'hEDCBA981);
        add(8'hFF, 7'h00, 0, 0, 0);
        run_rows("latency.post");

        add(8'hFE, hexlit(1), 0, 0, 0);
        add(8'hFD, hexlit(2), 0, 0, 0);
        add(8'hFB, hexlit(3), 0, 0, 0);
        run_rows("glitch.pre");
        se0 = se_n; fv0 = fv_n;
        drive(8'hF7, hexlit(5));
        repeat (3) @(negedge clk);
        drive(8'hF7, 7'h61);
        repeat (2) @(negedge clk);
        drive(8'hF7, hexlit(5));
        repeat (11) @(negedge clk);
        check("glitch.seg_err", se_n - se0, 0);
        check("glitch.frame_valid", fv_n - fv0, 0);
        add(8'hEF, hexlit(6), 0, 0, 0);
        add(8'hDF, hexlit(7), 0, 0, 0);
        add(8'hBF, hexlit(8), 0, 0, 0);
        add(8'h7F, hexlit(9), 0, 0, 1);
        run_rows("glitch.post");
        check("glitch.digits", digs(), 32'h98765321);

        add(8'hFE, hexlit(2), 0, 0, 0);
        add(8'hFC, hexlit(1), 1, 0, 0);
        add(8'hFD, hexlit(3), 0, 0, 0);
        add(8'hFB, 7'h61, 0, 1, 0);
        add(8'hF7, 7'h00, 0, 1, 0);
        add(8'hEF, hexlit(4), 0, 0, 0);
        add(8'hDF, hexlit(5), 0, 0, 0);
        add(8'hBF, hexlit(6), 0, 0, 0);
        add(8'h7F, hexlit(7), 0, 0, 0);
        add(8'hFF, 7'h7F, 0, 0, 0);
        add(8'hFB, hexlit(10), 0, 0, 0);
        add(8'hF7, hexlit(11), 0, 0, 1);
        run_rows("errors");
        check("errors.digits", digs(), 32'h7654BA32);
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
        check("errors.err_count", err_count, 3);
`endif

        fv0 = fv_n;
        for (int k = 0; k < 7; k++) add(~(8'h01 << k), hexlit(9 - k), 0, 0, 0);
        run_rows("partial");
        drive(8'h7F, hexlit(2));
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset.digits", digs(), 32'h0);
        check("midreset.frame_valid", frame_valid, 0);
        check("midreset.an_err", an_err, 0);
        check("midreset.seg_err", seg_err, 0);
`ifdef SEVENSEG_CAPTURE_ERRCNT_EN
        check("midreset.err_count", err_count, 0);
`endif
        @(negedge clk);
        drive(8'hFF, 7'h00);
        repeat (3) @(negedge clk);
        check("partial.no_frame", fv_n - fv0, 0);
        rst = 1'b1;
        add_frame(9, -1);
        run_rows("rescan");
        check("rescan.digits", digs(), 32'h23456789);

        drive(8'hFF, 7'h00);
        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
